// File: rtl/kappa3_phase_sequencer_if.sv
// Control/status bundle between the debug console, controller and the phase sequencer.
// Latency: none, this is wiring only; the sequencer registers every status output.
// Backpressure: none; memory wait states come in on mem_access/mem_ready.
interface kappa3_phase_sequencer_if #(
   parameter int CNT_W = 32
);
   logic             run;
   logic             step;
   logic             stop;
   logic             clear;
   logic             mem_access;
   logic             mem_ready;
   logic [31:0]      pc_next;
   logic             bp_en;
   logic [31:0]      bp_addr;
   logic [3:0]       cstate;
   logic             running;
   logic [1:0]       halt_reason;
   logic             fault;
   logic [CNT_W-1:0] instret;

   // Console / controller side: issues commands and memory status, observes the phase.
   modport master (
      output run, step, stop, clear, mem_access, mem_ready, pc_next, bp_en, bp_addr,
      input  cstate, running, halt_reason, fault, instret
   );

   // Sequencer side.
   modport slave (
      input  run, step, stop, clear, mem_access, mem_ready, pc_next, bp_en, bp_addr,
      output cstate, running, halt_reason, fault, instret
   );
endinterface

// File: rtl/kappa3_phase_sequencer.sv
// One-hot IF/DE/EX/WB phase generator with run/step/stop control, PC breakpoint and instret.
// Latency: all outputs registered, next phase visible one clock after the deciding inputs.
// Backpressure: IF/WB hold while a memory access is not ready; TIMEOUT held cycles fault.
module kappa3_phase_sequencer #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   kappa3_phase_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_STOP  = 3'd0,
      S_IF    = 3'd1,
      S_DE    = 3'd2,
      S_EX    = 3'd3,
      S_WB    = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   // Last wait count that may still be held; one more held cycle faults.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t           state_q, state_nxt;
   logic [15:0]      wait_q, wait_nxt;
   logic             step_mode_q, step_nxt;
   logic             stop_pend_q, pend_nxt;
   logic [1:0]       reason_q, reason_nxt;
   logic             retire;
   logic [3:0]       cstate_q;
   logic             running_q;
   logic             fault_q;
   logic [CNT_W-1:0] instret_q;
   logic             mem_hold;
   logic             bp_hit;

   assign mem_hold = bus.mem_access & ~bus.mem_ready;
   assign bp_hit   = bus.bp_en && (bus.pc_next == bus.bp_addr);

   function automatic logic [3:0] phase_of(state_t s);
      case (s)
         S_IF:    phase_of = 4'b0001;
         S_DE:    phase_of = 4'b0010;
         S_EX:    phase_of = 4'b0100;
         S_WB:    phase_of = 4'b1000;
         default: phase_of = 4'b0000;
      endcase
   endfunction

   // Next-state decision: commands, memory wait states, retire and halt selection.
   always_comb begin
      state_nxt  = state_q;
      wait_nxt   = wait_q;
      step_nxt   = step_mode_q;
      pend_nxt   = stop_pend_q;
      reason_nxt = reason_q;
      retire     = 1'b0;
      case (state_q)
         S_STOP: begin
            wait_nxt = '0;
            // step beats run; stop has no meaning here; no breakpoint check on resume.
            if (bus.step) begin
               state_nxt = S_IF;
               step_nxt  = 1'b1;
               pend_nxt  = 1'b0;
            end else if (bus.run) begin
               state_nxt = S_IF;
               step_nxt  = 1'b0;
               pend_nxt  = 1'b0;
            end
         end
         S_IF, S_WB: begin
            if (bus.stop) pend_nxt = 1'b1;
            if (mem_hold) begin
               if (wait_q == WAIT_LAST) begin
                  state_nxt  = S_FAULT;
                  reason_nxt = 2'b11;
                  wait_nxt   = '0;
                  step_nxt   = 1'b0;
                  pend_nxt   = 1'b0;
               end else begin
                  wait_nxt = wait_q + 16'd1;
               end
            end else begin
               wait_nxt = '0;
               if (state_q == S_IF) begin
                  state_nxt = S_DE;
               end else begin
                  retire = 1'b1;
                  // A stop arriving in this very WB cycle still halts here.
                  if (step_mode_q || stop_pend_q || bus.stop) begin
                     state_nxt  = S_STOP;
                     reason_nxt = 2'b01;
                     step_nxt   = 1'b0;
                     pend_nxt   = 1'b0;
                  end else if (bp_hit) begin
                     state_nxt  = S_STOP;
                     reason_nxt = 2'b10;
                     step_nxt   = 1'b0;
                     pend_nxt   = 1'b0;
                  end else begin
                     state_nxt = S_IF;
                  end
               end
            end
         end
         S_DE: begin
            if (bus.stop) pend_nxt = 1'b1;
            state_nxt = S_EX;
         end
         S_EX: begin
            if (bus.stop) pend_nxt = 1'b1;
            state_nxt = S_WB;
         end
         S_FAULT: begin
            wait_nxt = '0;
            if (bus.clear) state_nxt = S_STOP;
         end
         default: begin
            state_nxt = S_STOP;
            wait_nxt  = '0;
            step_nxt  = 1'b0;
            pend_nxt  = 1'b0;
         end
      endcase
   end

   // State register with outputs decoded from the next state, so every output is a flop.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_STOP;
         wait_q      <= '0;
         step_mode_q <= 1'b0;
         stop_pend_q <= 1'b0;
         reason_q    <= 2'b00;
         cstate_q    <= 4'b0000;
         running_q   <= 1'b0;
         fault_q     <= 1'b0;
         instret_q   <= '0;
      end else begin
         state_q     <= state_nxt;
         wait_q      <= wait_nxt;
         step_mode_q <= step_nxt;
         stop_pend_q <= pend_nxt;
         reason_q    <= reason_nxt;
         cstate_q    <= phase_of(state_nxt);
         running_q   <= (state_nxt == S_IF) || (state_nxt == S_DE) ||
                        (state_nxt == S_EX) || (state_nxt == S_WB);
         fault_q     <= (state_nxt == S_FAULT);
         if (retire) instret_q <= instret_q + CNT_W'(1);
      end
   end

   assign bus.cstate      = cstate_q;
   assign bus.running     = running_q;
   assign bus.halt_reason = reason_q;
   assign bus.fault       = fault_q;
   assign bus.instret     = instret_q;

endmodule

// File: tb/tb_kappa3_phase_sequencer.sv
// Bench for kappa3_phase_sequencer: directed scenarios then random commands and memory stalls.
// Expected outputs come from a phase-index reference model and are queued per clock edge.
// A monitor pops one entry per rising clock edge or reset assertion and compares.
module tb_kappa3_phase_sequencer;
   localparam int TO = 4;
   localparam int CW = 4;

   logic clock;
   logic reset;

   kappa3_phase_sequencer_if #(.CNT_W(CW)) bus ();

   kappa3_phase_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [3:0] cs;
      logic       run;
      logic [1:0] hr;
      logic       flt;
      int         cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: phase index 0..3 = IF,DE,EX,WB.
   bit m_active, m_faulted, m_single, m_stop_req;
   int m_phase, m_wait, m_reason, m_count;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic exp_t model_out();
      exp_t e;
      e.cs  = m_active ? 4'(1 << m_phase) : 4'b0000;
      e.run = m_active;
      e.hr  = 2'(m_reason);
      e.flt = m_faulted;
      e.cnt = m_count;
      return e;
   endfunction

   task automatic model_reset();
      m_active = 0; m_faulted = 0; m_single = 0; m_stop_req = 0;
      m_phase = 0; m_wait = 0; m_reason = 0; m_count = 0;
   endtask

   task automatic halt(input int why);
      m_active = 0; m_single = 0; m_stop_req = 0; m_reason = why;
   endtask

   task automatic model_step();
      if (m_faulted) begin
         if (bus.clear) m_faulted = 0;
      end else if (!m_active) begin
         if (bus.step || bus.run) begin
            m_active = 1; m_phase = 0; m_wait = 0; m_single = bus.step;
         end
      end else begin
         if (bus.stop) m_stop_req = 1;
         if ((m_phase == 0 || m_phase == 3) && bus.mem_access && !bus.mem_ready) begin
            m_wait++;
            if (m_wait == TO) begin
               halt(3); m_faulted = 1; m_wait = 0;
            end
         end else begin
            m_wait = 0;
            if (m_phase < 3) begin
               m_phase++;
            end else begin
               m_count = (m_count + 1) % (1 << CW);
               if (m_single || m_stop_req) halt(1);
               else if (bus.bp_en && bus.pc_next == bus.bp_addr) halt(2);
               else m_phase = 0;
            end
         end
      end
   endtask

   // One clock of stimulus: drive at the falling edge, record what the next rising edge must yield.
   task automatic cyc(input bit r, s, sp, cl, ma, mr, input logic [31:0] pc, input bit be);
      @(negedge clock);
      reset = 1'b1;
      bus.run = r; bus.step = s; bus.stop = sp; bus.clear = cl;
      bus.mem_access = ma; bus.mem_ready = mr; bus.pc_next = pc; bus.bp_en = be;
      model_step();
      exp_q.push_back(model_out());
   endtask

   task automatic idle(input int n, input logic [31:0] pc, input bit be);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 1, pc, be);
   endtask

   // Asynchronous assertion between edges: one entry for the reset edge, one for the next clock.
   task automatic async_reset();
      model_reset();
      exp_q.push_back(model_out());
      reset = 1'b0;
      exp_q.push_back(model_out());
   endtask

   task automatic run_to(input int ph);
      for (int k = 0; k < 20 && !(m_active && m_phase == ph); k++) idle(1, 32'h4, 0);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compares DUT outputs against the queued expectation after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock or negedge reset);
         #1;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_underflow: no expectation queued at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("cstate", int'(bus.cstate), int'(e.cs));
            chk("running", int'(bus.running), int'(e.run));
            chk("halt_reason", int'(bus.halt_reason), int'(e.hr));
            chk("fault", int'(bus.fault), int'(e.flt));
            chk("instret", int'(bus.instret), e.cnt);
         end
      end
   end

   initial begin
      bit r, s, sp, cl, ma, mr, be;
      logic [31:0] pc;
      reset = 1'b1;
      bus.run = 0; bus.step = 0; bus.stop = 0; bus.clear = 0;
      bus.mem_access = 0; bus.mem_ready = 1; bus.pc_next = 32'h0;
      bus.bp_en = 0; bus.bp_addr = 32'h10;
      model_reset();
      #2 async_reset();

      // Free run, no memory stalls: three instructions in 12 cycles, then stop from EX.
      idle(2, 32'h4, 0);
      cyc(1, 0, 0, 0, 0, 1, 32'h4, 0);
      idle(12, 32'h4, 0);
      run_to(2);
      cyc(0, 0, 1, 0, 0, 1, 32'h4, 0);
      idle(6, 32'h4, 0);

      // Single steps, then run+step together (step mode wins).
      cyc(0, 1, 0, 0, 0, 1, 32'h4, 0);
      idle(6, 32'h4, 0);
      cyc(0, 1, 0, 0, 0, 1, 32'h4, 0);
      idle(6, 32'h4, 0);
      cyc(1, 1, 0, 0, 0, 1, 32'h4, 0);
      idle(6, 32'h4, 0);

      // Stop in the final WB cycle.
      cyc(1, 0, 0, 0, 0, 1, 32'h4, 0);
      run_to(3);
      cyc(0, 0, 1, 0, 0, 1, 32'h4, 0);
      idle(3, 32'h4, 0);

      // IF held three cycles by memory, then ready.
      cyc(1, 0, 0, 0, 0, 1, 32'h4, 0);
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 0, 32'h4, 0);
      cyc(0, 0, 0, 0, 1, 1, 32'h4, 0);
      cyc(0, 0, 1, 0, 0, 1, 32'h4, 0);
      idle(6, 32'h4, 0);

      // Memory never ready: fault, commands ignored, clear returns to STOP.
      cyc(1, 0, 0, 0, 0, 1, 32'h4, 0);
      for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1, 0, 32'h4, 0);
      cyc(1, 0, 0, 0, 0, 1, 32'h4, 0);
      cyc(0, 1, 1, 0, 0, 1, 32'h4, 0);
      cyc(0, 0, 0, 1, 0, 1, 32'h4, 0);
      idle(2, 32'h4, 0);

      // Breakpoint at 0x10, then resume from it without re-triggering.
      cyc(1, 0, 0, 0, 0, 1, 32'h10, 1);
      idle(6, 32'h10, 1);
      cyc(1, 0, 0, 0, 0, 1, 32'h10, 1);
      idle(2, 32'h10, 1);
      idle(4, 32'h14, 1);
      cyc(0, 0, 1, 0, 0, 1, 32'h14, 1);
      idle(6, 32'h14, 1);

      // Asynchronous reset in the middle of DE.
      cyc(1, 0, 0, 0, 0, 1, 32'h4, 0);
      run_to(1);
      @(negedge clock);
      #2 async_reset();

      // Random commands, stalls and breakpoints; instret wraps several times.
      for (int i = 0; i < 3000; i++) begin
         if (m_active && $urandom_range(0, 299) == 0) begin
            @(negedge clock);
            #2 async_reset();
         end else begin
            r  = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 15) == 0);
            sp = ($urandom_range(0, 19) == 0);
            cl = ($urandom_range(0, 3) == 0);
            ma = ($urandom_range(0, 1) == 0);
            mr = ($urandom_range(0, 4) < 3);
            be = ($urandom_range(0, 1) == 0);
            pc = ($urandom_range(0, 3) == 0) ? 32'h10 : {$urandom} & 32'hFFFC;
            cyc(r, s, sp, cl, ma, mr, pc, be);
         end
      end

      @(negedge clock);
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
